// File: rtl/operand_frame_driver.sv
// operand_frame_driver: host-side driver for the nibble-serial add/multiply chip.
// Accepts an operand pair over valid/ready, streams it to the chip as a strobed
// nibble frame, collects the two result bytes and returns them (or a timeout
// error) over a second valid/ready handshake. All outputs are registered.
module operand_frame_driver #(
    parameter int FRAME_LEN = 6,   // strobe cycles per frame, 5..15
    parameter int TIMEOUT   = 64   // max cycles in WAIT, 2..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_op,
    output logic [11:0] chip_in,
    input  logic [11:0] chip_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_HI,
        S_RSP
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(FRAME_LEN - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        op_q, op_d;
    logic [7:0]  lo_q, lo_d;
    logic [11:0] chip_in_q, chip_in_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    // Pins [11:9] of the chip output carry nothing this driver uses.
    logic unused_chip_bits;
    assign unused_chip_bits = ^chip_out[11:9];

    // Next-state logic plus the registered output values derived from the next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        lo_d        = lo_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    beat_d  = 4'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat_q == LAST_BEAT) begin
                    tmo_d   = 8'd0;
                    state_d = S_WAIT;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (chip_out[8]) begin
                    lo_d    = chip_out[7:0];
                    state_d = S_HI;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_HI: begin
                // The high byte follows the low byte unconditionally; its valid bit is not checked.
                rsp_data_d = {chip_out[7:0], lo_q};
                rsp_err_d  = 1'b0;
                state_d    = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);

        // The op select stays on the pins from the first beat until the response is taken,
        // because the chip samples it after the frame has ended.
        chip_in_d = 12'h000;
        if (state_d != S_IDLE) begin
            chip_in_d[8] = op_d;
        end
        if (state_d == S_SEND) begin
            chip_in_d[9] = 1'b1;
            if (beat_d < 4'd4) begin
                chip_in_d[3:0] = a_d[{beat_d[1:0], 2'b00} +: 4];
                chip_in_d[7:4] = b_d[{beat_d[1:0], 2'b00} +: 4];
            end
        end
    end

    // State and output registers; reset drops every output at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= 4'd0;
            tmo_q       <= 8'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            op_q        <= 1'b0;
            lo_q        <= 8'h00;
            chip_in_q   <= 12'h000;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            chip_in_q   <= chip_in_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign chip_in   = chip_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_operand_frame_driver.sv
// Directed self-checking bench for operand_frame_driver (FRAME_LEN=6, TIMEOUT=64).
// The chip is emulated inline: the bench drives the result bytes it expects.
module tb_operand_frame_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_op;
    logic [11:0] chip_in;
    logic [11:0] chip_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_beats [6];
    logic [11:0] exp_wait;

    operand_frame_driver #(.FRAME_LEN(6), .TIMEOUT(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .chip_in   (chip_in),
        .chip_out  (chip_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Handshake a command and check every beat of the frame; ends in the first WAIT cycle.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic op,
                              input bit poke);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        step();
        cmd_valid = 1'b0;
        cmd_a     = 16'hDEAD;
        cmd_b     = 16'hBEEF;
        cmd_op    = ~op;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("beat%0d_chip_in", k), chip_in, exp_beats[k]);
            check($sformatf("beat%0d_cmd_ready", k), cmd_ready, 0);
            if (poke && k == 1) begin
                cmd_valid = 1'b1;
                cmd_a     = 16'hFFFF;
                cmd_b     = 16'hFFFF;
            end
            if (k == 2) cmd_valid = 1'b0;
            step();
        end
    endtask

    // From WAIT entry: optionally delay, return two bytes, check the response under backpressure.
    task automatic finish_rsp(input logic [7:0] lo, input logic [7:0] hi,
                              input logic [15:0] exp_data, input int delay,
                              input bit poke, input int hold);
        check("wait_entry_chip_in", chip_in, exp_wait);
        for (int d = 0; d < delay; d++) begin
            if (poke && d == 0) begin
                cmd_valid = 1'b1;
                cmd_a     = 16'h5555;
                cmd_b     = 16'h5555;
            end
            step();
            cmd_valid = 1'b0;
            check("wait_hold_chip_in", chip_in, exp_wait);
            check("wait_no_rsp", rsp_valid, 0);
        end
        chip_out = {3'b101, 1'b1, lo};
        step();
        chip_out = {3'b010, 1'b0, hi};
        check("hi_chip_in", chip_in, exp_wait);
        step();
        chip_out = 12'h000;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, 0);
        check("rsp_cmd_ready", cmd_ready, 0);
        check("rsp_chip_in", chip_in, exp_wait);
        for (int i = 0; i < hold; i++) begin
            step();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, exp_data);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_chip_in", chip_in, 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        cmd_op    = 1'b0;
        chip_out  = 12'h000;
        rsp_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_chip_in", chip_in, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        reset = 1'b0;
        step();
        check("rel_cmd_ready", cmd_ready, 1);

        // Add: 0x1234 + 0x0101 = 0x1335.
        exp_beats = '{12'h314, 12'h303, 12'h312, 12'h301, 12'h300, 12'h300};
        exp_wait  = 12'h100;
        send_frame(16'h1234, 16'h0101, 1'b1, 1'b0);
        finish_rsp(8'h35, 8'h13, 16'h1335, 2, 1'b0, 0);

        // Multiply: 0x00FF * 0x0003 = 0x02FD, with 10 cycles of backpressure.
        exp_beats = '{12'h23F, 12'h20F, 12'h200, 12'h200, 12'h200, 12'h200};
        exp_wait  = 12'h000;
        send_frame(16'h00FF, 16'h0003, 1'b0, 1'b0);
        finish_rsp(8'hFD, 8'h02, 16'h02FD, 0, 1'b0, 10);

        // Timeout: no result valid ever arrives.
        exp_beats = '{12'h300, 12'h321, 12'h300, 12'h300, 12'h300, 12'h300};
        exp_wait  = 12'h100;
        send_frame(16'h0010, 16'h0020, 1'b1, 1'b0);
        check("tmo_wait_chip_in", chip_in, exp_wait);
        for (int i = 0; i < 63; i++) step();
        check("tmo_not_yet", rsp_valid, 0);
        step();
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("tmo_post_cmd_ready", cmd_ready, 1);

        // Busy ignore: cmd_valid pulses during SEND and WAIT.
        exp_beats = '{12'h31D, 12'h31C, 12'h31B, 12'h31A, 12'h300, 12'h300};
        exp_wait  = 12'h100;
        send_frame(16'hABCD, 16'h1111, 1'b1, 1'b1);
        finish_rsp(8'hDE, 8'hBC, 16'hBCDE, 3, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_single_rsp", rsp_valid, 0);
            check("busy_idle_chip_in", chip_in, 0);
        end

        // Reset during beat 2.
        check("mid_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_a     = 16'h1234;
        cmd_b     = 16'h0101;
        cmd_op    = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("mid_beat2", chip_in, 12'h312);
        reset = 1'b1;
        #2;
        check("mid_rst_chip_in", chip_in, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        #2;
        reset = 1'b0;
        step();
        check("mid_rel_cmd_ready", cmd_ready, 1);
        check("mid_rel_chip_in", chip_in, 0);

        // Follow-up add: 0x0001 + 0x0001 = 0x0002.
        exp_beats = '{12'h311, 12'h300, 12'h300, 12'h300, 12'h300, 12'h300};
        exp_wait  = 12'h100;
        send_frame(16'h0001, 16'h0001, 1'b1, 1'b0);
        finish_rsp(8'h02, 8'h00, 16'h0002, 1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
